// File: rtl/vga_timing_pipelined.sv
// Programmable VGA timing generator with a pixel-request port and a FETCH_LAT-deep
// flag delay line so sync/blanking on the pins line up with returning colour data.
module vga_timing_pipelined #(
  parameter int H_ACTIVE   = 640,
  parameter int H_FRONT    = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BACK     = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FRONT    = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BACK     = 33,
  parameter bit HS_POL     = 1'b0,
  parameter bit VS_POL     = 1'b0,
  parameter int COLOR_BITS = 4,
  parameter int FETCH_LAT  = 2,
  parameter int CNT_W      = 11
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      pix_en,
  input  logic [3*COLOR_BITS-1:0]   color,
  output logic [CNT_W-1:0]          req_x,
  output logic [CNT_W-1:0]          req_y,
  output logic                      req_active,
  output logic                      line_start,
  output logic                      frame_start,
  output logic                      vga_hs,
  output logic                      vga_vs,
  output logic                      vga_de,
  output logic [COLOR_BITS-1:0]     vga_r,
  output logic [COLOR_BITS-1:0]     vga_g,
  output logic [COLOR_BITS-1:0]     vga_b
);

  localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_VIS    = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_VIS    = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HS_FIRST = CNT_W'(H_ACTIVE + H_FRONT);
  localparam logic [CNT_W-1:0] HS_LAST  = CNT_W'(H_ACTIVE + H_FRONT + H_SYNC - 1);
  localparam logic [CNT_W-1:0] VS_FIRST = CNT_W'(V_ACTIVE + V_FRONT);
  localparam logic [CNT_W-1:0] VS_LAST  = CNT_W'(V_ACTIVE + V_FRONT + V_SYNC - 1);

  logic [CNT_W-1:0] x_reg;
  logic [CNT_W-1:0] y_reg;
  logic             hs_a;
  logic             vs_a;
  logic [2:0]       flags_0;
  logic [2:0]       flags_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      x_reg <= '0;
      y_reg <= '0;
    end else if (pix_en) begin
      if (x_reg == H_LAST) begin
        x_reg <= '0;
        y_reg <= (y_reg == V_LAST) ? '0 : y_reg + CNT_W'(1);
      end else begin
        x_reg <= x_reg + CNT_W'(1);
      end
    end
  end

  assign req_x       = x_reg;
  assign req_y       = y_reg;
  assign req_active  = (x_reg < H_VIS) && (y_reg < V_VIS);
  assign line_start  = pix_en && (x_reg == '0);
  assign frame_start = pix_en && (x_reg == '0) && (y_reg == '0);

  assign hs_a    = (x_reg >= HS_FIRST) && (x_reg <= HS_LAST);
  assign vs_a    = (y_reg >= VS_FIRST) && (y_reg <= VS_LAST);
  assign flags_0 = {hs_a, vs_a, req_active};

  // Flags ride a shift line matching the memory fetch latency; each stage is its own register.
  generate
    if (FETCH_LAT == 0) begin : g_direct
      assign flags_d = flags_0;
    end else begin : g_delay
      for (genvar gi = 0; gi < FETCH_LAT; gi++) begin : g_stage
        logic [2:0] q_reg;
        if (gi == 0) begin : g_head
          always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n)    q_reg <= 3'b000;
            else if (pix_en) q_reg <= flags_0;
          end
        end else begin : g_tail
          always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n)    q_reg <= 3'b000;
            else if (pix_en) q_reg <= g_stage[gi-1].q_reg;
          end
        end
      end
      assign flags_d = g_stage[FETCH_LAT-1].q_reg;
    end
  endgenerate

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vga_hs <= ~HS_POL;
      vga_vs <= ~VS_POL;
      vga_de <= 1'b0;
      vga_r  <= '0;
      vga_g  <= '0;
      vga_b  <= '0;
    end else if (pix_en) begin
      vga_hs <= flags_d[2] ? HS_POL : ~HS_POL;
      vga_vs <= flags_d[1] ? VS_POL : ~VS_POL;
      vga_de <= flags_d[0];
      vga_r  <= flags_d[0] ? color[COLOR_BITS-1:0]              : '0;
      vga_g  <= flags_d[0] ? color[2*COLOR_BITS-1:COLOR_BITS]   : '0;
      vga_b  <= flags_d[0] ? color[3*COLOR_BITS-1:2*COLOR_BITS] : '0;
    end
  end

endmodule

// File: tb/tb_vga_timing_pipelined.sv
// Bench for vga_timing_pipelined on a small mode with FETCH_LAT=3 and mixed sync polarity;
// the reference model derives every pin from the count of pixel ticks since reset.
module tb_vga_timing_pipelined;
  localparam int HA = 10, HF = 3, HS = 4, HB = 2;
  localparam int VA = 6,  VF = 2, VS = 2, VB = 1;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FL = 3;
  localparam int CW = 6;
  localparam int CB = 4;
  localparam bit HSP = 1'b0;
  localparam bit VSP = 1'b1;

  logic            clk = 1'b0;
  logic            reset_n;
  logic            pix_en;
  logic [3*CB-1:0] color;
  logic [CW-1:0]   req_x, req_y;
  logic            req_active, line_start, frame_start;
  logic            vga_hs, vga_vs, vga_de;
  logic [CB-1:0]   vga_r, vga_g, vga_b;

  int checks = 0;
  int errors = 0;
  int n;
  logic [11:0] color_tab [256];

  always #5 clk = ~clk;

  vga_timing_pipelined #(
    .H_ACTIVE(HA), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_ACTIVE(VA), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
    .HS_POL(HSP), .VS_POL(VSP), .COLOR_BITS(CB), .FETCH_LAT(FL), .CNT_W(CW)
  ) dut (
    .clk(clk), .reset_n(reset_n), .pix_en(pix_en), .color(color),
    .req_x(req_x), .req_y(req_y), .req_active(req_active),
    .line_start(line_start), .frame_start(frame_start),
    .vga_hs(vga_hs), .vga_vs(vga_vs), .vga_de(vga_de),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h (tick %0d)", tag, obs, exp, n);
    end
  endtask

  // Expected pins after n ticks: pixel n-1-FL is on the pins (blank before the pipe fills).
  task automatic check_pins();
    int p, x, y;
    bit de, hs, vs;
    logic [11:0] c;
    p = n - 1 - FL;
    de = 0; hs = 0; vs = 0; c = '0;
    if (p >= 0) begin
      x  = p % HT;
      y  = (p / HT) % VT;
      de = (x < HA) && (y < VA);
      hs = (x >= HA + HF) && (x < HA + HF + HS);
      vs = (y >= VA + VF) && (y < VA + VF + VS);
      if (de) c = color_tab[p % 256];
    end
    chk("vga_de", vga_de, de);
    chk("vga_hs", vga_hs, hs ? HSP : !HSP);
    chk("vga_vs", vga_vs, vs ? VSP : !VSP);
    chk("vga_r", vga_r, c[3:0]);
    chk("vga_g", vga_g, c[7:4]);
    chk("vga_b", vga_b, c[11:8]);
  endtask

  // One clock: drive inputs, check request side, take the edge, check pins.
  task automatic step(input bit en);
    int x, y;
    pix_en = en;
    color  = color_tab[(n - FL) & 255];
    #1;
    x = n % HT;
    y = (n / HT) % VT;
    chk("req_x", req_x, x);
    chk("req_y", req_y, y);
    chk("req_active", req_active, (x < HA) && (y < VA));
    chk("line_start", line_start, en && (x == 0));
    chk("frame_start", frame_start, en && (x == 0) && (y == 0));
    @(posedge clk);
    if (en) n++;
    #1;
    check_pins();
  endtask

  initial begin
    bit reached;
    for (int i = 0; i < 256; i++) color_tab[i] = 12'($urandom);
    reset_n = 1'b0;
    pix_en  = 1'b0;
    color   = '0;
    n       = 0;
    repeat (2) @(posedge clk);
    #1;
    check_pins();
    chk("rst_req_x", req_x, 0);
    chk("rst_req_y", req_y, 0);
    reset_n = 1'b1;

    // Full-rate run over more than a whole frame.
    repeat (HT * VT + 30) step(1'b1);

    // Sparse pixel ticks, roughly one clock in four.
    repeat (HT * VT * 4) step($urandom_range(3) == 0);

    // Random ticks until mid-frame position (7,3), then asynchronous reset.
    reached = 0;
    for (int i = 0; i < 4 * HT * VT && !reached; i++) begin
      if ((n % HT) == 7 && ((n / HT) % VT) == 3) reached = 1;
      else step($urandom_range(1) == 1);
    end
    chk("reach_7_3", reached, 1);
    reset_n = 1'b0;
    #1;
    n = 0;
    check_pins();
    chk("async_req_x", req_x, 0);
    chk("async_req_y", req_y, 0);
    pix_en = 1'b1;
    @(posedge clk);
    #1;
    check_pins();
    chk("held_req_x", req_x, 0);
    reset_n = 1'b1;
    repeat (HT * 3) step(1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/vga_timing_pipelined.md
Name: vga_timing_pipelined

Overview:
Parametrised successor to the fixed-mode VGA controller. It generates programmable VGA timing and exposes a pixel request (x, y, active) to the frame-buffer or memory side. It accepts colour returning FETCH_LAT pixel ticks later and aligns sync and blanking to that latency. It sits between the memory-mapped frame buffer and the VGA DAC pins and advances only on a pixel-enable strobe, so one system clock serves any pixel rate.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FRONT, 16, horizontal front porch (pixels)
H_SYNC, 96, horizontal sync width (pixels)
H_BACK, 48, horizontal back porch (pixels)
V_ACTIVE, 480, visible lines per frame
V_FRONT, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines)
V_BACK, 33, vertical back porch (lines)
HS_POL, 0, asserted level of vga_hs (0 = active-low)
VS_POL, 0, asserted level of vga_vs
COLOR_BITS, 4, bits per colour channel
FETCH_LAT, 2, pixel ticks from request to colour valid; legal range 0..7
CNT_W, 11, width of x/y counters; must hold H_TOTAL-1 and V_TOTAL-1

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
pix_en  in  1  pixel tick; all state advances only on clk edges where pix_en=1
color  in  3*COLOR_BITS  {b,g,r}; r in LSBs; valid FETCH_LAT ticks after its request
req_x  out  CNT_W  horizontal counter (request stage)
req_y  out  CNT_W  vertical counter (request stage)
req_active  out  1  req_x<H_ACTIVE and req_y<V_ACTIVE
line_start  out  1  pix_en and req_x==0
frame_start  out  1  pix_en and req_x==0 and req_y==0
vga_hs  out  1  horizontal sync, polarity HS_POL
vga_vs  out  1  vertical sync, polarity VS_POL
vga_de  out  1  output-aligned display enable
vga_r/vga_g/vga_b  out  COLOR_BITS each  output colour, zero when blanked

Behaviour:
- H_TOTAL = sum of the H_* parameters; V_TOTAL = sum of the V_* parameters. Defaults give 800 x 525.
- Counters: on a pix_en edge, req_x increments and wraps H_TOTAL-1 -> 0. On that wrap, req_y increments and wraps V_TOTAL-1 -> 0. Without pix_en, all registers hold.
- Stage-0 flags are computed from the registered counters:
  - hs_a: true when req_x is in [H_ACTIVE+H_FRONT, H_ACTIVE+H_FRONT+H_SYNC-1], inclusive; exactly H_SYNC ticks.
  - vs_a: same rule on req_y with the V_* parameters; exactly V_SYNC lines.
  - de = req_active.
- req_active, line_start and frame_start are combinational from registers and pix_en. They carry no extra latency.
- Delay line: {hs_a, vs_a, de} pass through FETCH_LAT registers that advance on pix_en. FETCH_LAT=0 means a direct path.
- Output registers load on pix_en edges:
  - vga_de <= delayed de.
  - vga_hs <= delayed hs_a ? HS_POL : ~HS_POL; vga_vs likewise with VS_POL.
  - colour channels <= color slices when delayed de is 1, else 0.
- Latency: the pixel requested while req_x=k is driven on the pins after edge k+FETCH_LAT+1. Sync and de shift by the same amount, so active video, porches and sync widths are preserved exactly on the pins.
- Reset (asynchronous, immediate, including mid-frame):
  - counters 0; delay line cleared to blank/deasserted.
  - vga_de=0, colours 0, vga_hs=~HS_POL, vga_vs=~VS_POL.
  - After release, timing restarts at (0,0); the first pix_en edge consumes pixel (0,0), with frame_start=1 in that cycle.
- pix_en held at 1 runs the block at clk rate; irregular pix_en stretches all timing uniformly.
- Simultaneous x and y wrap at (H_TOTAL-1, V_TOTAL-1) returns to (0,0) in one edge.

Test Plan:
- Defaults, pix_en=1, FETCH_LAT=0, color=12'hABC: vga_r=4'hC, vga_g=4'hB, vga_b=4'hA for 640 clocks per visible line, then 0 for 160; frame period 420000 clocks; frame_start pulses once per frame.
- Defaults: vga_hs is low for exactly 96 clocks per line, starting 1+FETCH_LAT clocks after req_x=656; vga_vs is low for exactly 2x800 clocks, starting with line 490.
- FETCH_LAT=3, color driven as function of (req_x,req_y) delayed 3 ticks: every visible pin pixel matches its own coordinate; no colour outside vga_de.
- pix_en asserted 1 clock in 4: all periods scale x4; outputs hold between ticks.
- HS_POL=1, VS_POL=1: syncs idle low, pulse high with the same widths; reset value of vga_hs and vga_vs is 0.
- Assert reset_n=0 at req_x=300, req_y=200 with pix_en running: outputs clear immediately; after release, frame_start=1 on the first pix_en edge and req_x,req_y count from 0.
